// File: rtl/color_compress_stream.sv
// color_compress_stream: RGB565 -> RGB332 valid/ready stream compressor with
// optional round-to-nearest or 2x2 Bayer dither driven by internal x/y counters.
module color_compress_stream #(
    parameter int H_PIXELS = 240,
    parameter int V_PIXELS = 320,
    parameter int MODE     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_color,
    input  logic        in_sof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_color,
    output logic        out_sof,
    output logic        sof_mismatch
);
    localparam int XW = H_PIXELS > 1 ? $clog2(H_PIXELS) : 1;
    localparam int YW = V_PIXELS > 1 ? $clog2(V_PIXELS) : 1;
    localparam logic [XW-1:0] XMAX = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] YMAX = YW'(V_PIXELS - 1);
    logic [XW-1:0] x, px;
    logic [YW-1:0] y, py;
    logic          accept;
    logic [1:0]    d;
    logic [2:0]    or_, og;
    logic [5:0]    rs, bs;
    logic [6:0]    gs;
    logic [2:0]    r3, g3;
    logic [1:0]    b2;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    always_comb begin
        px  = in_sof ? '0 : x;
        py  = in_sof ? '0 : y;
        // {py,px}: 00->0, 01->2, 10->3, 11->1
        d   = {px[0] ^ py[0], py[0]};
        or_ = MODE == 1 ? 3'd2 : MODE == 2 ? {1'b0, d} : 3'd0;
        og  = MODE == 1 ? 3'd4 : MODE == 2 ? {d, 1'b0} : 3'd0;
        rs  = {1'b0, in_color[15:11]} + {3'b0, or_};
        gs  = {1'b0, in_color[10:5]} + {4'b0, og};
        bs  = {1'b0, in_color[4:0]} + {3'b0, og};
        r3  = 3'((rs > 6'd31 ? 6'd31 : rs) >> 2);
        g3  = 3'((gs > 7'd63 ? 7'd63 : gs) >> 3);
        b2  = 2'((bs > 6'd31 ? 6'd31 : bs) >> 3);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_color    <= 8'h00;
            out_sof      <= 1'b0;
            sof_mismatch <= 1'b0;
            x            <= '0;
            y            <= '0;
        end else begin
            sof_mismatch <= accept && in_sof && (x != '0 || y != '0);
            if (accept) begin
                out_valid <= 1'b1;
                out_color <= {r3, g3, b2};
                out_sof   <= in_sof;
                x         <= px == XMAX ? '0 : px + 1'b1;
                y         <= px == XMAX ? (py == YMAX ? '0 : py + 1'b1) : py;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_color_compress_stream.sv
// tb_color_compress_stream: scoreboard bench running MODE 0/1/2 instances in lockstep
// against a position-tracking arithmetic reference model.
`timescale 1ns/1ps
module tb_color_compress_stream;
    localparam int H = 24;
    localparam int V = 12;
    typedef struct packed {
        logic [23:0] c;
        logic        sof;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_color = 16'h0;
    logic [2:0]  ir, ov, os, mm;
    logic [7:0]  oc [3];
    int          n_vec = 0;
    int          n_bad = 0;
    int          mx = 0;
    int          my = 0;
    bit          mm_exp = 1'b0;
    int          rdy_pct = 100;
    exp_t        q[$];
    for (genvar m = 0; m < 3; m++) begin : g
        color_compress_stream #(.H_PIXELS(H), .V_PIXELS(V), .MODE(m)) u (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[m]),
            .in_color(in_color), .in_sof(in_sof), .out_valid(ov[m]), .out_ready(out_ready),
            .out_color(oc[m]), .out_sof(os[m]), .sof_mismatch(mm[m])
        );
    end
    always #5 clk = ~clk;
    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic int sat(int v, int lim, int sh);
        return ((v > lim) ? lim : v) >> sh;
    endfunction
    function automatic logic [7:0] ref_color(logic [15:0] c, int m, int px, int py);
        int r5 = int'(c[15:11]);
        int g6 = int'(c[10:5]);
        int b5 = int'(c[4:0]);
        int bay[4] = '{0, 2, 3, 1};
        int d = bay[(py % 2) * 2 + px % 2];
        int orr = m == 1 ? 2 : m == 2 ? d : 0;
        int og = m == 1 ? 4 : m == 2 ? 2 * d : 0;
        return 8'(sat(r5 + orr, 31, 2) * 32 + sat(g6 + og, 63, 3) * 4 + sat(b5 + og, 31, 3));
    endfunction
    function automatic logic [15:0] dec(logic [7:0] c);
        return {c[7:5], c[7:6], c[4:2], c[4:2], c[1:0], c[1:0], c[1]};
    endfunction
    task automatic model_accept(logic [15:0] c, logic s);
        int px = s ? 0 : mx;
        int py = s ? 0 : my;
        exp_t e;
        if (s && (mx != 0 || my != 0)) mm_exp = 1'b1;
        for (int m = 0; m < 3; m++) e.c[m*8 +: 8] = ref_color(c, m, px, py);
        e.sof = s;
        q.push_back(e);
        if (px == H - 1) begin
            mx = 0;
            my = (py == V - 1) ? 0 : py + 1;
        end else begin
            mx = px + 1;
            my = py;
        end
    endtask
    task automatic send(logic [15:0] c, logic s);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_color = c;
        in_sof   = s;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (ir[0]) begin
                model_accept(c, s);
                done = 1'b1;
            end
        end
        if (!done) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask
    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 99) < rdy_pct);
    end
    // Output monitor: handshake, hold-while-stalled and scoreboard pops
    initial begin
        bit          stall = 1'b0;
        logic [23:0] held = '0;
        logic        held_sof = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            chk("in_ready", ir, {3{!(ov[0] && !out_ready)}});
            chk("valid_agree", ov, {3{ov[0]}});
            if (stall) begin
                chk("hold_valid", ov[0], 1);
                chk("hold_color", {oc[2], oc[1], oc[0]}, held);
                chk("hold_sof", os[0], held_sof);
            end
            if (ov[0] && out_ready) begin
                if (q.size() == 0) chk("unexpected_output", 1, 0);
                else begin
                    e = q.pop_front();
                    for (int m = 0; m < 3; m++)
                        chk($sformatf("color_mode%0d", m), oc[m], e.c[m*8 +: 8]);
                    chk("out_sof", os, {3{e.sof}});
                end
            end
            stall    = ov[0] && !out_ready;
            held     = {oc[2], oc[1], oc[0]};
            held_sof = os[0];
        end
    end
    initial forever begin
        @(posedge clk);
        #2;
        if (rst_n) chk("sof_mismatch", mm, {3{mm_exp}});
        mm_exp = 1'b0;
    end
    initial begin
        #2;
        chk("rst_valid", ov, 0);
        chk("rst_color", {oc[2], oc[1], oc[0]}, 0);
        chk("rst_sof", os, 0);
        chk("rst_mismatch", mm, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_pct = 60;
        repeat (1500) begin
            send(16'($urandom), $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        rdy_pct = 80;
        for (int c = 0; c < 256; c++) send(dec(8'(c)), 1'b0);
        send(16'hFFFF, 1'b0);
        send(16'h2963, 1'b0);
        send(16'h3000, 1'b0);
        send(16'h0841, 1'b1);
        send(16'h0841, 1'b0);
        repeat (H - 2) send(16'($urandom), 1'b0);
        send(16'h0841, 1'b0);
        send(16'h0841, 1'b0);
        rdy_pct = 100;
        send(16'($urandom), 1'b1);
        repeat (H * V - 1) send(16'($urandom), 1'b0);
        send(16'h1000, 1'b1);
        repeat (4) send(16'($urandom), 1'b0);
        send(16'h1000, 1'b1);
        send(16'h1000, 1'b0);
        send(16'h1000, 1'b0);
        rdy_pct = 0;
        idle(1);
        send(16'hFFFF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", ov, 0);
        chk("midrst_color", {oc[2], oc[1], oc[0]}, 0);
        chk("midrst_sof", os, 0);
        q.delete();
        mx = 0;
        my = 0;
        mm_exp = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_pct = 100;
        send(16'h1000, 1'b0);
        send(16'h1000, 1'b0);
        repeat (20) send(16'($urandom), $urandom_range(0, 9) == 0);
        idle(1);
        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        chk("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
